// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache for the MEM stage.
// Ports: cpu_* load/store port with stall; mem_* registered line req/ack port.
module dcache_ctrl #(
    parameter int INDEX_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_wdata_o,
    input  logic [255:0] mem_rdata_i,
    input  logic         mem_ack_i
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 27 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [255:0]     data_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    // Line address of the miss being serviced; the fill and the install
    // use this, not the live CPU address, so a dropped request is safe.
    logic [26:0] fill_line_q, fill_line_d;

    logic         req_d;
    logic         we_d;
    logic [31:0]  addr_d;
    logic [255:0] wdata_d;

    logic [2:0]         word;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] fidx;
    logic               hit;
    logic               idle_hit;
    logic               unused_addr_lsb;

    assign word = cpu_addr_i[4:2];
    assign idx  = cpu_addr_i[4+INDEX_W:5];
    assign tag  = cpu_addr_i[31:5+INDEX_W];
    assign fidx = fill_line_q[INDEX_W-1:0];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign hit = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign idle_hit = (state_q == IDLE) & hit;

    assign cpu_stall_o = cpu_req_i & ~idle_hit;
    assign cpu_rdata_o = (idle_hit & ~cpu_we_i)
                       ? data_q[idx][{word, 5'b0} +: 32] : 32'h0;

    always_comb begin
        state_d     = state_q;
        req_d       = mem_req_o;
        we_d        = mem_we_o;
        addr_d      = mem_addr_o;
        wdata_d     = mem_wdata_o;
        fill_line_d = fill_line_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    fill_line_d = cpu_addr_i[31:5];
                    req_d       = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WB;
                        we_d    = 1'b1;
                        addr_d  = {tag_q[idx], idx, 5'b0};
                        wdata_d = data_q[idx];
                    end else begin
                        state_d = ALLOC;
                        we_d    = 1'b0;
                        addr_d  = {cpu_addr_i[31:5], 5'b0};
                    end
                end
            end
            WB: begin
                if (mem_ack_i) begin
                    state_d = ALLOC;
                    we_d    = 1'b0;
                    addr_d  = {fill_line_q, 5'b0};
                end
            end
            ALLOC: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= '0;
            fill_line_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            fill_line_q <= fill_line_d;
            if (idle_hit && cpu_we_i) begin
                dirty_q[idx] <= 1'b1;
            end
            if (state_q == WB && mem_ack_i) begin
                dirty_q[fidx] <= 1'b0;
            end
            if (state_q == ALLOC && mem_ack_i) begin
                valid_q[fidx] <= 1'b1;
                dirty_q[fidx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; validity lives in valid_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (idle_hit && cpu_we_i) begin
                data_q[idx][{word, 5'b0} +: 32] <= cpu_wdata_i;
            end
            if (state_q == ALLOC && mem_ack_i) begin
                data_q[fidx] <= mem_rdata_i;
                tag_q[fidx]  <= fill_line_q[26:INDEX_W];
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl.
// Table of accesses plus hand sequences for reset and dropped requests.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = 32'h0;
    logic [31:0]  cpu_wdata_i = 32'h0;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i = '0;
    logic         mem_ack_i = 1'b0;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.INDEX_W(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    // kind: 0 hit, 1 miss with clean/invalid victim, 2 miss with dirty victim
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        int          kind;
        logic [31:0] wb_addr;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  ref_mem  [logic [29:0]];
    logic [255:0] mem_line [logic [26:0]];
    logic [31:0]  sb [$];
    vec_t         vecs [$];

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [29:0] w);
        return {w, 2'b00} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return dflt(a[31:2]);
    endfunction

    function automatic logic [255:0] mem_get(input logic [26:0] la);
        logic [255:0] l;
        if (mem_line.exists(la)) return mem_line[la];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = dflt({la, i[2:0]});
        return l;
    endfunction

    task automatic add(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int dly,
                       input int kind, input logic [31:0] wb_addr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata;
        v.dly = dly; v.kind = kind; v.wb_addr = wb_addr;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 after the access retires.
    task automatic do_access(input vec_t v);
        int           ncyc = 0;
        int           waitc = 0;
        int           nwb = 0;
        int           nfill = 0;
        int           exp_cyc;
        bit           held = 0;
        bit           done = 0;
        logic [31:0]  h_addr;
        logic         h_we;
        logic [255:0] h_wdata;
        logic [255:0] exp_line;
        cpu_req_i   = 1'b1;
        cpu_we_i    = v.we;
        cpu_addr_i  = v.addr;
        cpu_wdata_i = v.wdata;
        if (v.we) ref_mem[v.addr[31:2]] = v.wdata;
        else sb.push_back(ref_word(v.addr));
        while (!done) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                done = 1;
                if (!v.we) chk("load data", cpu_rdata_o, sb.pop_front());
                else chk("store rdata", cpu_rdata_o, 0);
                chk("req at retire", mem_req_o, 0);
            end else if (ncyc > 300) begin
                chk("timeout", ncyc, 0);
                if (!v.we) void'(sb.pop_front());
                done = 1;
            end else begin
                ncyc++;
                if (mem_req_o) begin
                    if (held) begin
                        chk("hold addr", mem_addr_o, h_addr);
                        chk("hold we", mem_we_o, h_we);
                        chk("hold wdata", mem_wdata_o, h_wdata);
                    end
                    if (waitc == v.dly) begin
                        mem_ack_i = 1'b1;
                        held = 0;
                        waitc = 0;
                        if (mem_we_o) begin
                            nwb++;
                            chk("wb addr", mem_addr_o, v.wb_addr);
                            for (int i = 0; i < 8; i++)
                                exp_line[32*i +: 32] =
                                    ref_word({v.wb_addr[31:5], i[2:0], 2'b00});
                            chk("wb data", mem_wdata_o, exp_line);
                            mem_line[mem_addr_o[31:5]] = mem_wdata_o;
                        end else begin
                            nfill++;
                            chk("fill addr", mem_addr_o, {v.addr[31:5], 5'b0});
                            mem_rdata_i = mem_get(mem_addr_o[31:5]);
                        end
                    end else begin
                        waitc++;
                        held = 1;
                        h_addr = mem_addr_o;
                        h_we = mem_we_o;
                        h_wdata = mem_wdata_o;
                    end
                end
                @(posedge clk_i);
                #1;
                mem_ack_i = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
        exp_cyc = (v.kind == 0) ? 0 :
                  (v.kind == 1) ? 2 + v.dly : 3 + 2 * v.dly;
        chk("stall cycles", ncyc, exp_cyc);
        chk("wb count", nwb, (v.kind == 2) ? 1 : 0);
        chk("fill count", nfill, (v.kind != 0) ? 1 : 0);
    endtask

    initial begin
        logic [255:0] l;
        vec_t         v;

        ref_mem[30'h11] = 32'hDEADBEEF;
        l = mem_get(27'd2);
        l[63:32] = 32'hDEADBEEF;
        mem_line[27'd2] = l;

        add(0, 32'h0000_0044, 0, 0, 1, 0);
        add(1, 32'h0000_0044, 32'h0000_1234, 0, 0, 0);
        add(0, 32'h0000_0044, 0, 0, 0, 0);
        add(0, 32'h0000_0444, 0, 0, 2, 32'h0000_0040);
        add(0, 32'h0000_0040, 0, 2, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 32'h40 + 4 * i, 0, 0, 0, 0);
        add(1, 32'h0000_0808, 32'hCAFE_F00D, 1, 1, 0);
        add(0, 32'h0000_0808, 0, 0, 0, 0);
        add(0, 32'h0000_0008, 0, 3, 2, 32'h0000_0800);
        add(0, 32'h0000_0808, 0, 0, 1, 0);
        add(1, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 1, 1, 0);
        add(0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        add(1, 32'h0000_07E4, 32'h600D_F00D, 2, 2, 32'hFFFF_FFE0);
        add(0, 32'h0000_1004, 0, 50, 1, 0);
        add(0, 32'h0000_07E4, 0, 0, 0, 0);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst req", mem_req_o, 0);
        chk("rst we", mem_we_o, 0);
        chk("rst addr", mem_addr_o, 0);
        chk("rst wdata", mem_wdata_o, 0);
        chk("rst stall", cpu_stall_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        foreach (vecs[i]) do_access(vecs[i]);

        // CPU drops a store mid-miss: line installs, no write happens.
        cpu_req_i = 1'b1; cpu_we_i = 1'b1;
        cpu_addr_i = 32'h0000_0C0C; cpu_wdata_i = 32'hFFFF_0000;
        @(negedge clk_i);
        chk("drop stall t0", cpu_stall_o, 1);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        chk("drop req", mem_req_o, 1);
        chk("drop stall idle", cpu_stall_o, 0);
        mem_ack_i = 1'b1;
        mem_rdata_i = mem_get(27'h60);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("drop req done", mem_req_o, 0);
        @(posedge clk_i);
        #1;
        v.we = 0; v.addr = 32'h0000_0C0C; v.wdata = 0;
        v.dly = 0; v.kind = 0; v.wb_addr = 0;
        do_access(v);

        // Reset during ALLOC, with an ack on the same edge.
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_2040;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("alloc req", mem_req_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        mem_ack_i = 1'b1;
        mem_rdata_i = mem_get(27'h102);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("post rst req", mem_req_o, 0);
        chk("post rst we", mem_we_o, 0);
        chk("post rst addr", mem_addr_o, 0);
        chk("post rst stall", cpu_stall_o, 0);
        @(posedge clk_i);
        #1;
        v.we = 0; v.addr = 32'h0000_0044; v.wdata = 0;
        v.dly = 0; v.kind = 1; v.wb_addr = 0;
        do_access(v);
        cpu_req_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
